alu_seq_ctrl: RTL and testbench

- Multi-cycle controller that sequences the 8-bit combinational ALU (2-bit OPCODE: 00 add, 01 sub, 10 mul, 11 div).
- Owns the 4x8 register file, fetches operands, drives the ALU ports and writes the result back to REG_A.
- Also handles load-immediate and divide-by-zero.
- Sits between the instruction source (valid/ready) and the ALU instance.

---
 rtl/alu_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for an external 8-bit combinational ALU.
// It owns a 4-entry register file, handles load-immediate, and keeps a sticky divide-by-zero flag.
module alu_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              IN_LOAD,
  input  logic [1:0]        IN_OPCODE,
  input  logic [1:0]        IN_REG_A,
  input  logic [1:0]        IN_REG_B,
  input  logic [DATA_W-1:0] IN_IMM,
  output logic [1:0]        ALU_OPCODE,
  output logic [1:0]        ALU_REG_A,
  output logic [1:0]        ALU_REG_B,
  output logic [DATA_W-1:0] ALU_DATA_A,
  output logic [DATA_W-1:0] ALU_DATA_B,
  input  logic [DATA_W-1:0] ALU_DATA_OUT,
  output logic              DONE,
  output logic              ERR,
  input  logic              ERR_CLR,
  output logic [CNT_W-1:0]  OP_COUNT,
  input  logic [1:0]        DBG_SEL,
  output logic [DATA_W-1:0] DBG_DATA
);

  // state | meaning
  // IDLE  | ready for an instruction; fields latched on accept
  // READ  | register operands and latched fields move onto the ALU ports
  // EXEC  | ALU inputs stable; result and divide-by-zero captured
  // WB    | DONE pulse; result written to the destination unless faulted
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t state, state_nxt;

  logic [1:0]        op_q, ra_q, rb_q;
  logic [DATA_W-1:0] result_q;
  logic              fault_q;
  logic [DATA_W-1:0] rf [4];
  logic              div_zero;

  assign div_zero = (ALU_OPCODE == 2'b11) && (ALU_DATA_B == '0);
  assign DBG_DATA = rf[DBG_SEL];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nxt = IN_LOAD ? WB : READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      result_q   <= '0;
      fault_q    <= 1'b0;
      ALU_OPCODE <= '0;
      ALU_REG_A  <= '0;
      ALU_REG_B  <= '0;
      ALU_DATA_A <= '0;
      ALU_DATA_B <= '0;
      OP_COUNT   <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            op_q     <= IN_OPCODE;
            ra_q     <= IN_REG_A;
            rb_q     <= IN_REG_B;
            result_q <= IN_IMM;
            fault_q  <= 1'b0;
          end
        end
        READ: begin
          ALU_OPCODE <= op_q;
          ALU_REG_A  <= ra_q;
          ALU_REG_B  <= rb_q;
          ALU_DATA_A <= rf[ra_q];
          ALU_DATA_B <= rf[rb_q];
        end
        EXEC: begin
          result_q <= ALU_DATA_OUT;
          fault_q  <= div_zero;
        end
        WB: begin
          if (!fault_q) rf[ra_q] <= result_q;
          OP_COUNT <= OP_COUNT + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // A new fault takes priority over a simultaneous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         ERR <= 1'b0;
    else if (state == EXEC && div_zero) ERR <= 1'b1;
    else if (ERR_CLR)                ERR <= 1'b0;
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU and a result scoreboard.
module tb_alu_seq_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID, IN_READY, IN_LOAD;
  logic [1:0] IN_OPCODE, IN_REG_A, IN_REG_B;
  logic [7:0] IN_IMM;
  logic [1:0] ALU_OPCODE, ALU_REG_A, ALU_REG_B;
  logic [7:0] ALU_DATA_A, ALU_DATA_B, ALU_DATA_OUT;
  logic       DONE, ERR, ERR_CLR;
  logic [7:0] OP_COUNT;
  logic [1:0] DBG_SEL;
  logic [7:0] DBG_DATA;

  alu_seq_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LOAD(IN_LOAD),
    .IN_OPCODE(IN_OPCODE), .IN_REG_A(IN_REG_A), .IN_REG_B(IN_REG_B), .IN_IMM(IN_IMM),
    .ALU_OPCODE(ALU_OPCODE), .ALU_REG_A(ALU_REG_A), .ALU_REG_B(ALU_REG_B),
    .ALU_DATA_A(ALU_DATA_A), .ALU_DATA_B(ALU_DATA_B), .ALU_DATA_OUT(ALU_DATA_OUT),
    .DONE(DONE), .ERR(ERR), .ERR_CLR(ERR_CLR), .OP_COUNT(OP_COUNT),
    .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return p[7:0];
      default: return (b == 8'd0) ? 8'hFF : a / b;
    endcase
  endfunction

  assign ALU_DATA_OUT = alu_f(ALU_OPCODE, ALU_DATA_A, ALU_DATA_B);

  typedef struct {
    logic [1:0] dest;
    logic [7:0] val;
    logic       fault;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mrf [4];
  logic [7:0] mcount;
  logic       merr;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mrf[i] = 8'd0;
    mcount = 8'd0;
    merr   = 1'b0;
    sb.delete();
  endtask

  task automatic issue(input bit ld, input logic [1:0] op, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [7:0] imm, input bit clr_exec);
    int   waitc;
    int   lat;
    exp_t e;
    waitc = 0;
    @(negedge CLK);
    while (!IN_READY && waitc < 20) begin
      @(negedge CLK);
      waitc++;
    end
    chk("ready_wait", 32'(IN_READY), 32'd1);
    IN_VALID = 1'b1; IN_LOAD = ld; IN_OPCODE = op; IN_REG_A = ra; IN_REG_B = rb; IN_IMM = imm;
    DBG_SEL = ra;
    e.dest = ra;
    if (ld) begin
      e.val = imm; e.fault = 1'b0;
    end else begin
      e.val = alu_f(op, mrf[ra], mrf[rb]);
      e.fault = (op == 2'b11) && (mrf[rb] == 8'd0);
    end
    sb.push_back(e);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 0;
    while (!DONE && lat < 10) begin
      chk("ready_busy", 32'(IN_READY), 32'd0);
      if (lat == 1) begin
        chk("alu_opcode", 32'(ALU_OPCODE), 32'(op));
        chk("alu_reg_a", 32'(ALU_REG_A), 32'(ra));
        chk("alu_reg_b", 32'(ALU_REG_B), 32'(rb));
        chk("alu_data_a", 32'(ALU_DATA_A), 32'(mrf[ra]));
        chk("alu_data_b", 32'(ALU_DATA_B), 32'(mrf[rb]));
        ERR_CLR = clr_exec;
      end
      @(posedge CLK); #1;
      ERR_CLR = 1'b0;
      lat++;
    end
    chk("done_latency", 32'(lat), ld ? 32'd0 : 32'd2);
    chk("ready_wb", 32'(IN_READY), 32'd0);
    e = sb.pop_front();
    chk("dbg_pre_write", 32'(DBG_DATA), 32'(mrf[e.dest]));
    if (!e.fault) mrf[e.dest] = e.val;
    if (e.fault) merr = 1'b1;
    else if (clr_exec) merr = 1'b0;
    mcount = mcount + 8'd1;
    chk("err_wb", 32'(ERR), 32'(merr));
    @(posedge CLK); #1;
    chk("done_pulse", 32'(DONE), 32'd0);
    chk("dbg_post_write", 32'(DBG_DATA), 32'(mrf[e.dest]));
    chk("op_count", 32'(OP_COUNT), 32'(mcount));
    chk("ready_idle", 32'(IN_READY), 32'd1);
  endtask

  task automatic read_reg(input string tag, input logic [1:0] r, input logic [7:0] exp);
    DBG_SEL = r;
    #1;
    chk(tag, 32'(DBG_DATA), 32'(exp));
  endtask

  initial begin
    exp_t e;
    int   nd;
    bit   pend;
    logic [7:0] v;
    RST = 1'b1; IN_VALID = 1'b0; IN_LOAD = 1'b0; IN_OPCODE = 2'b00; IN_REG_A = 2'b00;
    IN_REG_B = 2'b00; IN_IMM = 8'd0; ERR_CLR = 1'b0; DBG_SEL = 2'b00;
    model_reset();
    #22;
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_count", 32'(OP_COUNT), 32'd0);
    chk("rst_alu_a", 32'(ALU_DATA_A), 32'd0);
    @(negedge CLK); RST = 1'b0; #1;
    chk("rst_ready", 32'(IN_READY), 32'd1);

    // basic ALU ops
    issue(1, 2'b00, 2'd0, 2'd0, 8'd15, 0);
    issue(1, 2'b00, 2'd1, 2'd0, 8'd10, 0);
    issue(0, 2'b00, 2'd0, 2'd1, 8'd0, 0);
    read_reg("add_r0", 2'd0, 8'd25);
    chk("add_count", 32'(OP_COUNT), 32'd3);
    issue(1, 2'b00, 2'd2, 2'd0, 8'd20, 0);
    issue(1, 2'b00, 2'd3, 2'd0, 8'd5, 0);
    issue(0, 2'b01, 2'd2, 2'd3, 8'd0, 0);
    read_reg("sub_r2", 2'd2, 8'd15);
    issue(1, 2'b00, 2'd3, 2'd0, 8'd4, 0);
    issue(1, 2'b00, 2'd2, 2'd0, 8'd20, 0);
    issue(0, 2'b11, 2'd2, 2'd3, 8'd0, 0);
    read_reg("div_r2", 2'd2, 8'd5);
    issue(1, 2'b00, 2'd0, 2'd0, 8'd4, 0);
    issue(1, 2'b00, 2'd1, 2'd0, 8'd5, 0);
    issue(0, 2'b10, 2'd0, 2'd1, 8'd0, 0);
    read_reg("mul_r0", 2'd0, 8'd20);
    issue(0, 2'b00, 2'd0, 2'd0, 8'd0, 0);
    read_reg("self_add_r0", 2'd0, 8'd40);

    // divide-by-zero and ERR handling
    issue(1, 2'b00, 2'd2, 2'd0, 8'd20, 0);
    issue(1, 2'b00, 2'd3, 2'd0, 8'd0, 0);
    issue(0, 2'b11, 2'd2, 2'd3, 8'd0, 0);
    read_reg("dz_r2_kept", 2'd2, 8'd20);
    chk("dz_err", 32'(ERR), 32'd1);
    issue(0, 2'b11, 2'd2, 2'd3, 8'd0, 1);
    chk("dz_set_wins", 32'(ERR), 32'd1);
    @(negedge CLK); ERR_CLR = 1'b1;
    @(posedge CLK); #1; ERR_CLR = 1'b0; merr = 1'b0;
    chk("err_clear", 32'(ERR), 32'd0);
    issue(0, 2'b00, 2'd2, 2'd2, 8'd0, 0);
    read_reg("after_err_r2", 2'd2, 8'd40);

    // IN_VALID held high across three dependent instructions
    issue(1, 2'b00, 2'd1, 2'd0, 8'd1, 0);
    v = mrf[1];
    for (int k = 0; k < 3; k++) begin
      v = alu_f(2'b00, v, v);
      e.dest = 2'd1; e.val = v; e.fault = 1'b0;
      sb.push_back(e);
    end
    @(negedge CLK);
    IN_VALID = 1'b1; IN_LOAD = 1'b0; IN_OPCODE = 2'b00; IN_REG_A = 2'd1; IN_REG_B = 2'd1;
    DBG_SEL = 2'd1;
    nd = 0; pend = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        nd++;
        chk("hold_done_cycle", 32'(c), 32'(4 * nd - 1));
        pend = 1'b1;
      end else if (pend) begin
        e = sb.pop_front();
        chk("hold_value", 32'(DBG_DATA), 32'(e.val));
        mrf[1] = e.val;
        mcount = mcount + 8'd1;
        pend = 1'b0;
      end
    end
    @(negedge CLK); IN_VALID = 1'b0;
    chk("hold_done_total", 32'(nd), 32'd3);
    chk("hold_count", 32'(OP_COUNT), 32'(mcount));
    read_reg("hold_r1", 2'd1, 8'd8);

    // reset during EXEC aborts the instruction
    issue(1, 2'b00, 2'd0, 2'd0, 8'd7, 0);
    issue(1, 2'b00, 2'd1, 2'd0, 8'd3, 0);
    @(negedge CLK);
    IN_VALID = 1'b1; IN_LOAD = 1'b0; IN_OPCODE = 2'b00; IN_REG_A = 2'd0; IN_REG_B = 2'd1;
    @(posedge CLK); #1; IN_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("pre_rst_alu_a", 32'(ALU_DATA_A), 32'd7);
    RST = 1'b1; #1;
    model_reset();
    chk("mid_rst_done", 32'(DONE), 32'd0);
    chk("mid_rst_op", 32'(ALU_OPCODE), 32'd0);
    chk("mid_rst_reg_a", 32'(ALU_REG_A), 32'd0);
    chk("mid_rst_reg_b", 32'(ALU_REG_B), 32'd0);
    chk("mid_rst_data_a", 32'(ALU_DATA_A), 32'd0);
    chk("mid_rst_data_b", 32'(ALU_DATA_B), 32'd0);
    chk("mid_rst_count", 32'(OP_COUNT), 32'd0);
    chk("mid_rst_err", 32'(ERR), 32'd0);
    @(posedge CLK); #1;
    chk("mid_rst_no_done", 32'(DONE), 32'd0);
    @(negedge CLK); RST = 1'b0; #1;
    chk("post_rst_ready", 32'(IN_READY), 32'd1);
    for (int r = 0; r < 4; r++) read_reg("post_rst_reg", 2'(r), 8'd0);

    // completed-instruction counter wraps
    for (int i = 0; i < 256; i++) issue(1, 2'b00, 2'(i), 2'd0, 8'(i * 3 + 1), 0);
    chk("wrap_count", 32'(OP_COUNT), 32'd0);
    read_reg("wrap_r3", 2'd3, 8'(255 * 3 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
